// File: rtl/sg_desc_fetch_ctrl.sv
// sg_desc_fetch_ctrl: SG DMA descriptor chain fetch, dispatch and CSR status reporting.
// Define SG_DESC_IRQ_EN to build the chain-complete interrupt (irq_o tied 0 otherwise).
module sg_desc_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       csr_control_i,
  input  logic [31:0]       csr_next_pointer_i,
  output logic [31:0]       csr_status_update_data_o,
  output logic              csr_status_update_req_o,
  input  logic              csr_status_update_ack_i,
  output logic              mm_rd_o,
  output logic [ADDR_W-1:0] mm_addr_o,
  input  logic              mm_wait_rq_i,
  input  logic [31:0]       mm_rd_data_i,
  input  logic              mm_rd_valid_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_src_o,
  output logic [ADDR_W-1:0] desc_dst_o,
  output logic [LEN_W-1:0]  desc_len_o,
  input  logic              xfer_done_i,
  output logic              irq_o
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, CHECK, DISPATCH, WAIT_DONE, STAT_DESC, STAT_END} state_t;
  state_t state_q, state_d;
  logic run_q, rise_q, rd_q, rd_d, dv_q, dv_d, req_q, req_d, ack, unused;
  logic [1:0] beat_q, beat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] stat_q, stat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, nxt_q, nxt_d, src_q, src_d, dst_q, dst_d, addr_q, addr_d, rd_word, nptr;
  assign ack = req_q & csr_status_update_ack_i;
  assign rd_word = ADDR_W'(mm_rd_data_i);
  assign nptr = ADDR_W'(csr_next_pointer_i) & ~ADDR_W'(3);
  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    nxt_d = nxt_q;
    stat_d = stat_q;
    rd_d = rd_q;
    dv_d = dv_q;
    req_d = req_q;
    case (state_q)
      IDLE: if (rise_q) begin
        state_d = RD_REQ;
        ptr_d = nptr;
        addr_d = nptr;
        beat_d = '0;
        cnt_d = '0;
        rd_d = 1'b1;
      end
      RD_REQ: if (!mm_wait_rq_i) begin
        state_d = RD_DATA;
        rd_d = 1'b0;
      end
      RD_DATA: if (mm_rd_valid_i) begin
        src_d = beat_q == 2'd0 ? rd_word : src_q;
        dst_d = beat_q == 2'd1 ? rd_word : dst_q;
        len_d = beat_q == 2'd2 ? mm_rd_data_i[LEN_W-1:0] : len_q;
        nxt_d = beat_q == 2'd3 ? rd_word & ~ADDR_W'(3) : nxt_q;
        beat_d = beat_q + 2'd1;
        state_d = beat_q == 2'd3 ? CHECK : RD_REQ;
        rd_d = beat_q != 2'd3;
        addr_d = ptr_q + ADDR_W'({beat_d, 2'b00});
      end
      CHECK: begin
        state_d = len_q == '0 ? STAT_END : DISPATCH;
        dv_d = len_q != '0;
        stat_d = len_q == '0 ? {cnt_q, 16'h0004} : stat_q;
      end
      DISPATCH: if (desc_ready_i) begin
        state_d = WAIT_DONE;
        dv_d = 1'b0;
      end
      WAIT_DONE: if (xfer_done_i) begin
        state_d = STAT_DESC;
        cnt_d = cnt_q + 16'd1;
        stat_d = {cnt_d, 16'h0001};
        req_d = 1'b1;
      end
      STAT_DESC: if (ack) begin
        req_d = 1'b0;
        state_d = (nxt_q == '0 || !csr_control_i[0]) ? STAT_END : RD_REQ;
        stat_d = {cnt_q, nxt_q == '0 ? 16'h0002 : 16'h0008};
        ptr_d = nxt_q;
        addr_d = nxt_q;
        beat_d = '0;
        rd_d = nxt_q != '0 && csr_control_i[0];
      end
      STAT_END: begin
        // req drops for a cycle after the BUSY ack, then re-asserts with the final status
        req_d = !ack;
        state_d = ack ? IDLE : STAT_END;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      run_q <= 1'b0;
      rise_q <= 1'b0;
      beat_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      nxt_q <= '0;
      stat_q <= '0;
      rd_q <= 1'b0;
      dv_q <= 1'b0;
      req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= csr_control_i[0];
      rise_q <= csr_control_i[0] & ~run_q;
      beat_q <= beat_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      nxt_q <= nxt_d;
      stat_q <= stat_d;
      rd_q <= rd_d;
      dv_q <= dv_d;
      req_q <= req_d;
    end
  end
  assign mm_rd_o = rd_q;
  assign mm_addr_o = addr_q;
  assign desc_valid_o = dv_q;
  assign desc_src_o = src_q;
  assign desc_dst_o = dst_q;
  assign desc_len_o = len_q;
  assign csr_status_update_req_o = req_q;
  assign csr_status_update_data_o = stat_q;
`ifdef SG_DESC_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = state_q == STAT_END && ack && csr_control_i[1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign irq_o = irq_q;
  assign unused = ^csr_control_i[31:2];
`else
  assign irq_o = 1'b0;
  assign unused = ^csr_control_i[31:1];
`endif
endmodule

// File: tb/tb_sg_desc_fetch_ctrl.sv
// tb_sg_desc_fetch_ctrl: table-driven descriptor chains plus hand-written stop, reset and latency sequences.
module tb_sg_desc_fetch_ctrl;
`ifdef SG_DESC_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] csr_control_i = '0, csr_next_pointer_i = '0, csr_status_update_data_o;
  logic csr_status_update_req_o, csr_status_update_ack_i = 1'b0;
  logic mm_rd_o, mm_wait_rq_i = 1'b0, mm_rd_valid_i;
  logic [31:0] mm_addr_o, mm_rd_data_i;
  logic desc_valid_o, desc_ready_i = 1'b0, xfer_done_i = 1'b0, irq_o;
  logic [31:0] desc_src_o, desc_dst_o;
  logic [23:0] desc_len_o;

  sg_desc_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .csr_control_i(csr_control_i), .csr_next_pointer_i(csr_next_pointer_i),
    .csr_status_update_data_o(csr_status_update_data_o),
    .csr_status_update_req_o(csr_status_update_req_o),
    .csr_status_update_ack_i(csr_status_update_ack_i),
    .mm_rd_o(mm_rd_o), .mm_addr_o(mm_addr_o), .mm_wait_rq_i(mm_wait_rq_i),
    .mm_rd_data_i(mm_rd_data_i), .mm_rd_valid_i(mm_rd_valid_i),
    .desc_valid_o(desc_valid_o), .desc_ready_i(desc_ready_i),
    .desc_src_o(desc_src_o), .desc_dst_o(desc_dst_o), .desc_len_o(desc_len_o),
    .xfer_done_i(xfer_done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ptr, src0, dst0, len0, nxt0, len1;
    bit irq_en;
    int w_n, r_n, a_n, exp_reads, exp_disp;
    logic [31:0] exp_first, exp_final;
  } vec_t;

  int tests = 0, fails = 0;
  int wait_n = 0, ready_n = 0, ack_n = 0, done_n = 2;
  int unstable = 0, irq_n = 0;
  bit slave_en = 1'b1;
  logic man_valid = 1'b0, s_valid = 1'b0;
  logic [31:0] man_data = '0, s_data = '0;
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q[$], upd_q[$];
  logic [87:0] disp_q[$];

  assign mm_rd_valid_i = slave_en ? s_valid : man_valid;
  assign mm_rd_data_i = slave_en ? s_data : man_data;

  // memory slave: wait_n stall cycles per request, read data one cycle after accept
  bit pend = 1'b0, hold_rd = 1'b0;
  int wcnt = 0;
  logic [31:0] paddr = '0, hold_addr = '0;
  always @(negedge clk) begin
    s_valid = 1'b0;
    mm_wait_rq_i = 1'b0;
    if (slave_en) begin
      if (pend) begin
        s_valid = 1'b1;
        s_data = mem[paddr[11:2]];
        pend = 1'b0;
      end
      if (mm_rd_o) begin
        if (hold_rd && mm_addr_o != hold_addr) unstable++;
        if (wcnt < wait_n) begin
          mm_wait_rq_i = 1'b1;
          wcnt++;
          hold_rd = 1'b1;
          hold_addr = mm_addr_o;
        end else begin
          wcnt = 0;
          hold_rd = 1'b0;
          pend = 1'b1;
          paddr = mm_addr_o;
          rd_q.push_back(mm_addr_o);
        end
      end else begin
        if (hold_rd) unstable++;
        hold_rd = 1'b0;
      end
    end
  end

  // dispatcher: ready after ready_n cycles, done pulse done_n cycles after handshake
  bit dv_hold = 1'b0;
  int rcnt = 0, done_cd = 0;
  logic [87:0] dv_held = '0;
  always @(negedge clk) begin
    desc_ready_i = 1'b0;
    xfer_done_i = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) xfer_done_i = 1'b1;
    end
    if (desc_valid_o) begin
      if (dv_hold && {desc_src_o, desc_dst_o, desc_len_o} != dv_held) unstable++;
      if (rcnt < ready_n) begin
        rcnt++;
        dv_hold = 1'b1;
        dv_held = {desc_src_o, desc_dst_o, desc_len_o};
      end else begin
        desc_ready_i = 1'b1;
        rcnt = 0;
        dv_hold = 1'b0;
        disp_q.push_back({desc_src_o, desc_dst_o, desc_len_o});
        done_cd = done_n;
      end
    end else begin
      if (dv_hold) unstable++;
      dv_hold = 1'b0;
    end
  end

  // CSR: ack after ack_n cycles of req
  bit rq_hold = 1'b0;
  int acnt = 0;
  logic [31:0] rq_held = '0;
  always @(negedge clk) begin
    csr_status_update_ack_i = 1'b0;
    if (csr_status_update_req_o) begin
      if (rq_hold && csr_status_update_data_o != rq_held) unstable++;
      if (acnt < ack_n) begin
        acnt++;
        rq_hold = 1'b1;
        rq_held = csr_status_update_data_o;
      end else begin
        csr_status_update_ack_i = 1'b1;
        acnt = 0;
        rq_hold = 1'b0;
        upd_q.push_back(csr_status_update_data_o);
      end
    end else begin
      if (rq_hold) unstable++;
      rq_hold = 1'b0;
    end
  end

  always @(negedge clk) if (irq_o) irq_n++;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_env();
    rd_q.delete();
    upd_q.delete();
    disp_q.delete();
    unstable = 0;
    irq_n = 0;
  endtask

  task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] l, input logic [31:0] n);
    mem[a[11:2]] = s;
    mem[a[11:2] + 10'd1] = d;
    mem[a[11:2] + 10'd2] = l;
    mem[a[11:2] + 10'd3] = n;
  endtask

  task automatic wait_final(output logic [31:0] fin);
    logic [31:0] last;
    fin = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (upd_q.size() > 0) begin
        last = upd_q[upd_q.size() - 1];
        if (last[3:1] != 3'b0) begin
          fin = last;
          break;
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    logic [31:0] p0, p1, fin, exp_a;
    p0 = v.ptr & ~32'h3;
    p1 = v.nxt0 & ~32'h3;
    put_desc(p0, v.src0, v.dst0, v.len0, v.nxt0);
    if (p1 != 0) put_desc(p1, 32'h3000, 32'h4000, v.len1, 32'h0);
    wait_n = v.w_n;
    ready_n = v.r_n;
    ack_n = v.a_n;
    clear_env();
    csr_next_pointer_i = v.ptr;
    csr_control_i = {30'b0, v.irq_en, 1'b1};
    wait_final(fin);
    csr_control_i = '0;
    check($sformatf("v%0d final", k), fin, v.exp_final);
    check($sformatf("v%0d nreads", k), rd_q.size(), v.exp_reads);
    for (int i = 0; i < v.exp_reads && i < rd_q.size(); i++) begin
      exp_a = (i < 4 ? p0 : p1) + 32'(4 * (i % 4));
      check($sformatf("v%0d rd%0d", k, i), rd_q[i], exp_a);
    end
    check($sformatf("v%0d ndisp", k), disp_q.size(), v.exp_disp);
    if (disp_q.size() > 0) check($sformatf("v%0d desc0", k), disp_q[0], {v.src0, v.dst0, v.len0[23:0]});
    check($sformatf("v%0d nupd", k), upd_q.size(), v.exp_disp + 1);
    if (upd_q.size() > 0) check($sformatf("v%0d upd0", k), upd_q[0], v.exp_first);
    check($sformatf("v%0d irq", k), irq_n, (IRQ_BUILT && v.irq_en) ? 1 : 0);
    check($sformatf("v%0d stable", k), unstable, 0);
    wait_n = 0;
    ready_n = 0;
    ack_n = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] fin;
    vecs[0] = '{32'h100, 32'h1000, 32'h2000, 32'h40, 32'h0, 32'h0, 1'b1, 0, 0, 0, 4, 1, 32'h0001_0001, 32'h0001_0002};
    vecs[1] = '{32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200, 32'h80, 1'b1, 0, 0, 0, 8, 2, 32'h0001_0001, 32'h0002_0002};
    vecs[2] = '{32'h300, 32'h1100, 32'h2100, 32'h0, 32'h0, 32'h0, 1'b1, 0, 0, 0, 4, 0, 32'h0000_0004, 32'h0000_0004};
    vecs[3] = '{32'h102, 32'h1200, 32'h2200, 32'h10, 32'h0, 32'h0, 1'b0, 0, 0, 0, 4, 1, 32'h0001_0001, 32'h0001_0002};
    vecs[4] = '{32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200, 32'h80, 1'b0, 3, 5, 4, 8, 2, 32'h0001_0001, 32'h0002_0002};
    vecs[5] = '{32'h140, 32'h1300, 32'h2300, 32'hAB00_0020, 32'h203, 32'h8, 1'b1, 1, 2, 1, 8, 2, 32'h0001_0001, 32'h0002_0002};
    vecs[6] = '{32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200, 32'h0, 1'b1, 0, 0, 0, 8, 1, 32'h0001_0001, 32'h0001_0004};
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst outputs", {mm_rd_o, desc_valid_o, csr_status_update_req_o, irq_o}, 4'b0);
    check("rst addr/data", {mm_addr_o, csr_status_update_data_o}, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // RUN cleared while the descriptor is in flight: finish it, stop at the status point
    put_desc(32'h100, 32'h1000, 32'h2000, 32'h40, 32'h200);
    put_desc(32'h200, 32'h3000, 32'h4000, 32'h80, 32'h0);
    clear_env();
    done_n = 8;
    csr_next_pointer_i = 32'h100;
    csr_control_i = 32'h1;
    for (int i = 0; i < 500 && disp_q.size() == 0; i++) @(negedge clk);
    csr_control_i = '0;
    wait_final(fin);
    done_n = 2;
    check("stop final", fin, 32'h0001_0008);
    check("stop nreads", rd_q.size(), 4);
    check("stop ndisp", disp_q.size(), 1);
    check("stop nupd", upd_q.size(), 2);
    if (upd_q.size() > 0) check("stop upd0", upd_q[0], 32'h0001_0001);
    repeat (3) @(negedge clk);

    // reset while a read response is outstanding
    slave_en = 1'b0;
    clear_env();
    csr_next_pointer_i = 32'h100;
    csr_control_i = 32'h1;
    for (int i = 0; i < 20 && !mm_rd_o; i++) @(negedge clk);
    check("rstmid rd", mm_rd_o, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    csr_control_i = '0;
    #1;
    check("rstmid ctl", {mm_rd_o, desc_valid_o, csr_status_update_req_o, irq_o}, 4'b0);
    check("rstmid addr", mm_addr_o, 32'h0);
    check("rstmid desc", {desc_src_o, desc_dst_o, desc_len_o}, 88'h0);
    check("rstmid stat", csr_status_update_data_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    man_valid = 1'b1;
    man_data = 32'hDEAD_BEEF;
    @(negedge clk);
    man_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("late valid ignored", {desc_src_o, 31'b0, mm_rd_o}, {32'h0, 31'b0, 1'b0});

    // restart: RUN edge to first read is two cycles, from the new pointer
    put_desc(32'h300, 32'h5000, 32'h6000, 32'h20, 32'h0);
    pend = 1'b0;
    hold_rd = 1'b0;
    wcnt = 0;
    slave_en = 1'b1;
    clear_env();
    csr_next_pointer_i = 32'h300;
    csr_control_i = 32'h1;
    @(negedge clk);
    check("lat cyc1 rd", mm_rd_o, 1'b0);
    @(negedge clk);
    check("lat cyc2 rd", {mm_rd_o, mm_addr_o}, {1'b1, 32'h300});
    wait_final(fin);
    csr_control_i = '0;
    check("restart final", fin, 32'h0001_0002);
    if (rd_q.size() > 0) check("restart rd0", rd_q[0], 32'h300);
    if (disp_q.size() > 0) check("restart desc", disp_q[0], {32'h5000, 32'h6000, 24'h20});
    check("restart stable", unstable, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
